// File: rtl/fp_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_share_ctrl
// Purpose  : Shares one combinational, truncating FP32 multiplier among NREQ
//            requesters. Round-robin grant, operand/result pipeline registers,
//            tagged results and a single global backpressure signal.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid_i  [NREQ]      requester i has an operand pair
//   req_a_i      [NREQ*32]   operand A of requester i at [32*i+31:32*i]
//   req_b_i      [NREQ*32]   operand B of requester i
//   req_ready_o  [NREQ]      one-hot accept strobe
//   rsp_valid_o              result available
//   rsp_data_o   [32]        FP32 product
//   rsp_id_o     [ID_W]      index of the requester that issued it
//   rsp_ready_i              consumer takes the result
//   busy_o                   any pipeline stage valid
//   inflight_o   [3]         number of valid stages (0..LAT)
// ============================================================================
module fp_mul_share_ctrl #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*32-1:0]   req_a_i,
  input  logic [NREQ*32-1:0]   req_b_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_data_o,
  output logic [ID_W-1:0]      rsp_id_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o,
  output logic [2:0]           inflight_o
);

  // (p + k) mod NREQ for 1 <= k <= NREQ
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return ID_W'(s);
  endfunction

  // Truncating FP32 multiply: no rounding, no special-value handling.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [24:0] mt;
    logic [7:0]  e;
    m  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    mt = 25'(m >> 23);
    e  = a[30:23] + b[30:23] - 8'd127;
    if (mt[24]) fp_mul = {a[31] ^ b[31], e + 8'd1, mt[23:1]};
    else        fp_mul = {a[31] ^ b[31], e, mt[22:0]};
  endfunction

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic [ID_W-1:0] id_q [LAT];
  logic [31:0]     a_q, b_q;
  logic            zf_q;

  logic            adv;
  logic            accept;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [31:0]     sel_a, sel_b;
  logic [31:0]     prod;
  logic [2:0]      cnt;

  assign rsp_valid_o = vld_q[LAT-1];
  assign rsp_id_o    = id_q[LAT-1];
  assign adv         = !rsp_valid_o || rsp_ready_i;
  assign accept      = gnt_vld && adv;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_vld && req_valid_i[wrap_inc(ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_inc(ptr_q, k);
      end
    end
  end

  // Ready is forced low while reset is asserted so nothing appears accepted.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = rst_n && accept && (gnt_idx == ID_W'(i));
    end
  end

  assign sel_a = req_a_i[{gnt_idx, 5'd0} +: 32];
  assign sel_b = req_b_i[{gnt_idx, 5'd0} +: 32];

  always_comb begin
    ptr_d    = accept ? gnt_idx : ptr_q;
    vld_d    = vld_q;
    if (adv) begin
      vld_d[0] = accept;
      for (int k = 1; k < LAT; k++) vld_d[k] = vld_q[k-1];
    end
  end

  // Stage 1 plus the id shift chain. zf_q resets to 1 so that the product
  // seen from the reset operands is +0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(NREQ - 1);
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      zf_q  <= 1'b1;
      for (int k = 0; k < LAT; k++) id_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      if (adv) begin
        id_q[0] <= gnt_idx;
        for (int k = LAT - 1; k >= 1; k--) id_q[k] <= id_q[k-1];
      end
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        zf_q <= (sel_a[30:23] == 8'd0) || (sel_b[30:23] == 8'd0);
      end
    end
  end

  // Zero/denormal operands bypass the multiplier with a signed zero.
  assign prod = zf_q ? {a_q[31] ^ b_q[31], 31'd0} : fp_mul(a_q, b_q);

  generate
    if (LAT == 1) begin : g_lat1
      assign rsp_data_o = prod;
    end else begin : g_latn
      logic [31:0] prod_q [LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < LAT - 1; k++) prod_q[k] <= '0;
        end else if (adv) begin
          prod_q[0] <= prod;
          for (int k = 1; k < LAT - 1; k++) prod_q[k] <= prod_q[k-1];
        end
      end
      assign rsp_data_o = prod_q[LAT-2];
    end
  endgenerate

  always_comb begin
    cnt = 3'd0;
    for (int k = 0; k < LAT; k++) cnt = cnt + 3'(vld_q[k]);
  end

  assign inflight_o = cnt;
  assign busy_o     = |vld_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_share_ctrl
// Purpose  : Directed self-checking bench for fp_mul_share_ctrl. Per-requester
//            queues of hand-computed operand/product vectors feed the DUT; a
//            behavioural model tracks grants and pipeline occupancy and a
//            compare process checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_share_ctrl;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int LAT  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_a, req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [31:0]          rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_ready;
  logic                 busy;
  logic [2:0]           inflight;

  always #5 clk = ~clk;

  fp_mul_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_ready_i (rsp_ready),
    .busy_o      (busy),
    .inflight_o  (inflight)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t tbl [14];
  vec_t rq [NREQ][$];
  int   log_id [$];

  int n_cmp = 0, n_fail = 0;
  int n_pushed = 0, n_issued = 0, n_rsp = 0, n_dropped = 0;
  bit chk_en = 1'b0;

  // model state
  int              m_ptr = NREQ - 1;
  bit [LAT-1:0]    m_v = '0;
  logic [ID_W-1:0] m_id [LAT];
  logic [31:0]     m_d  [LAT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int r, input vec_t v);
    rq[r].push_back(v);
    n_pushed++;
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Requester side: present the head of each queue until it is accepted.
  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() != 0) begin
          req_valid[i]       = 1'b1;
          req_a[32*i +: 32]  = rq[i][0].a;
          req_b[32*i +: 32]  = rq[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Behavioural model: round-robin pick, LAT-deep occupancy, global stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (chk_en) n_dropped += $countones(m_v);
      m_v   = '0;
      m_ptr = NREQ - 1;
    end else begin
      int g;
      bit adv;
      adv = !m_v[LAT-1] || rsp_ready;
      g   = rr_pick(m_ptr, req_valid);
      if (adv) begin
        for (int s = LAT - 1; s >= 1; s--) begin
          m_v[s]  = m_v[s-1];
          m_id[s] = m_id[s-1];
          m_d[s]  = m_d[s-1];
        end
        m_v[0] = (g >= 0);
        if (g >= 0) begin
          m_id[0] = ID_W'(g);
          m_d[0]  = rq[g][0].p;
          void'(rq[g].pop_front());
          m_ptr = g;
          n_issued++;
        end
      end
    end
  end

  // Compare process: every cycle, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        logic [NREQ-1:0] exp_rdy;
        int  g;
        bit  adv;
        adv = !m_v[LAT-1] || rsp_ready;
        g   = rr_pick(m_ptr, req_valid);
        exp_rdy = (rst_n && adv && g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(rst_n && m_v[LAT-1]));
        chk("busy",      32'(busy),      32'(rst_n && (m_v != '0)));
        chk("inflight",  32'(inflight),  rst_n ? 32'($countones(m_v)) : 32'd0);
        if (!rst_n) begin
          chk("rsp_data_rst", rsp_data, 32'd0);
          chk("rsp_id_rst",   32'(rsp_id), 32'd0);
        end else if (m_v[LAT-1]) begin
          chk("rsp_data", rsp_data, m_d[LAT-1]);
          chk("rsp_id",   32'(rsp_id), 32'(m_id[LAT-1]));
          if (rsp_ready) begin
            log_id.push_back(int'(rsp_id));
            n_rsp++;
          end
        end
      end
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      sync();
      if (!busy && all_empty()) return;
    end
    timeout(nm);
  endtask

  task automatic wait_inflight(input string nm, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      sync();
      if (int'(inflight) == n) return;
    end
    timeout(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lat_n;
    bit seen;

    tbl[0]  = {32'h3FC00000, 32'h3FC00000, 32'h40100000}; // 1.5*1.5
    tbl[1]  = {32'h40000000, 32'h40400000, 32'h40C00000}; // 2*3
    tbl[2]  = {32'h00000000, 32'hC0000000, 32'h80000000}; // 0*-2
    tbl[3]  = {32'h3F800000, 32'h3F800000, 32'h3F800000}; // 1*1
    tbl[4]  = {32'hBFC00000, 32'h40000000, 32'hC0400000}; // -1.5*2
    tbl[5]  = {32'h40800000, 32'h3F000000, 32'h40000000}; // 4*0.5
    tbl[6]  = {32'hC0000000, 32'hC0000000, 32'h40800000}; // -2*-2
    tbl[7]  = {32'h40400000, 32'h40400000, 32'h41100000}; // 3*3
    tbl[8]  = {32'h3FA00000, 32'h3FA00000, 32'h3FC80000}; // 1.25*1.25
    tbl[9]  = {32'h3FC00001, 32'h3FC00001, 32'h40100001}; // truncated, not rounded
    tbl[10] = {32'h00000001, 32'h40000000, 32'h00000000}; // denormal operand
    tbl[11] = {32'h40E00000, 32'h40A00000, 32'h420C0000}; // 7*5
    tbl[12] = {32'h80000000, 32'h3F800000, 32'h80000000}; // -0*1
    tbl[13] = {32'h3F000000, 32'h00000000, 32'h00000000}; // 0.5*0

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    sync();
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  rsp_data, 32'd0);
    chk("reset_rsp_id",    32'(rsp_id), 32'd0);
    chk("reset_busy",      32'(busy), 32'd0);
    chk("reset_inflight",  32'(inflight), 32'd0);
    sync();
    rst_n = 1'b1;

    // Single request from req0: latency and product pinned by hand.
    sync();
    push(0, tbl[0]);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sync();
      #2;
      if (req_ready[0]) begin seen = 1'b1; break; end
    end
    if (!seen) timeout("req0_ready");
    lat_n = 0;
    for (int i = 0; i < 10; i++) begin
      sync();
      #2;
      lat_n++;
      if (rsp_valid) break;
    end
    chk("lat_cycles", 32'(lat_n), 32'(LAT));
    chk("lit_1p5sq_data", rsp_data, 32'h40100000);
    chk("lit_1p5sq_id", 32'(rsp_id), 32'd0);
    wait_idle("idle_a", 20);

    // Single requests on req1, req2, req3.
    push(1, tbl[1]);
    for (int i = 0; i < 20; i++) begin sync(); #2; if (rsp_valid) break; end
    chk("lit_2x3_data", rsp_data, 32'h40C00000);
    chk("lit_2x3_id", 32'(rsp_id), 32'd1);
    wait_idle("idle_b", 20);
    push(2, tbl[2]);
    for (int i = 0; i < 20; i++) begin sync(); #2; if (rsp_valid) break; end
    chk("lit_zero_data", rsp_data, 32'h80000000);
    chk("lit_zero_id", 32'(rsp_id), 32'd2);
    wait_idle("idle_c", 20);
    push(3, tbl[9]);
    for (int i = 0; i < 20; i++) begin sync(); #2; if (rsp_valid) break; end
    chk("lit_trunc_data", rsp_data, 32'h40100001);
    wait_idle("idle_d", 20);

    // All four requesters continuously valid: grants rotate 0,1,2,3.
    base = log_id.size();
    for (int r = 0; r < NREQ; r++)
      for (int j = 0; j < 3; j++) push(r, tbl[3 + ((r * 3 + j) % 11)]);
    wait_idle("idle_rr", 60);
    for (int k = 0; k < 12; k++)
      chk("rr_order", (base + k < log_id.size()) ? 32'(log_id[base + k]) : 32'hFFFFFFFF, 32'(k % NREQ));

    // Backpressure with a full pipe.
    for (int r = 0; r < NREQ; r++)
      for (int j = 0; j < 3; j++) push(r, tbl[(r + 5 * j) % 14]);
    wait_inflight("fill", LAT, 20);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sync();
      #2;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    sync();
    rsp_ready = 1'b1;
    wait_idle("idle_stall", 80);
    chk("no_loss_dup", 32'(n_rsp), 32'(n_pushed));

    // Reset mid-stream with two operations in flight.
    for (int r = 0; r < NREQ; r++)
      for (int j = 0; j < 3; j++) push(r, tbl[(r * 4 + j + 1) % 14]);
    wait_inflight("fill2", 2, 20);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy",      32'(busy), 32'd0);
    chk("midrst_inflight",  32'(inflight), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_data",  rsp_data, 32'd0);
    chk("midrst_rsp_id",    32'(rsp_id), 32'd0);
    sync();
    sync();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    wait_idle("idle_end", 80);
    chk("dropped_count", 32'(n_dropped), 32'd2);
    chk("rsp_accounting", 32'(n_rsp), 32'(n_issued - n_dropped));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
